// File: rtl/uart_pkg.sv
// Shared UART types, the default oversampling ratio and a parity helper.
// The receiver and the planned configurable transmitter both use this package.
package uart_pkg;

  localparam int unsigned OVS_DEF = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_t;

  // XOR of the low nbits bits of data
  function automatic logic parity_of(input logic [7:0] data, input logic [3:0] nbits);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < 32'(nbits)) p ^= data[i];
    end
    return p;
  endfunction

  function automatic parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Received-word handshake between the UART receiver and the command decoder.
interface uart_rx_cfg_if;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_perr, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_perr, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator: baud divisor down-counter plus a phase counter.
// The divisor is captured on restart so it stays fixed for a whole frame.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned OVS   = OVS_DEF,
  parameter int unsigned DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     anrst,
  input  logic                     restart_i,
  input  logic [DIV_W-1:0]         div_i,
  output logic                     tick_o,
  output logic [$clog2(OVS)-1:0]   phase_o,
  output logic                     sample_strobe_o
);

  localparam int unsigned PH_W = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVS / 2 - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVS / 2);
  localparam logic [PH_W-1:0] PH_S2   = PH_W'(OVS / 2 + 1);

  logic [DIV_W-1:0] reload_q, cnt_q, div_m1;
  logic [PH_W-1:0]  phase_q;

  // A divisor of 0 behaves like 1
  assign div_m1 = (div_i == '0) ? '0 : div_i - DIV_W'(1);

  assign tick_o          = (cnt_q == '0) && !restart_i;
  assign phase_o         = phase_q;
  assign sample_strobe_o = tick_o && (phase_q == PH_S0 || phase_q == PH_S1 || phase_q == PH_S2);

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      reload_q <= '0;
      cnt_q    <= '0;
      phase_q  <= '0;
    end else if (restart_i) begin
      reload_q <= div_m1;
      cnt_q    <= div_m1;
      phase_q  <= '0;
    end else if (cnt_q == '0) begin
      cnt_q   <= reload_q;
      phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5-8 data bits, optional parity, 1/2 stop
// bits, 3-sample majority vote, break detection and a valid/ready output stage.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned OVS   = OVS_DEF,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             anrst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             rxd,
  uart_rx_cfg_if.master    rx,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             overrun_err,
  output logic             break_det
);

  localparam int unsigned PH_W = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_S0 = PH_W'(OVS / 2 - 1);
  localparam logic [PH_W-1:0] PH_S1 = PH_W'(OVS / 2);
  localparam logic [PH_W-1:0] PH_S2 = PH_W'(OVS / 2 + 1);

  logic sync1_q, rxs_q, rxs_d1_q, fall;
  logic restart, tick, sample_strobe;
  logic [PH_W-1:0] phase;
  logic [1:0] smp_q;
  logic bit_q, vote_q;

  rx_state_t state_q, state_d;
  logic [1:0] bits_q, bits_d;
  parity_t    par_q, par_d;
  logic       stop2_q, stop2_d;
  logic [7:0] data_q, data_d;
  logic [2:0] idx_q, idx_d, last_idx;
  logic [3:0] nbits;
  logic       par_bit_q, par_bit_d, perr_q, perr_d, ferr_q, ferr_d;
  logic       stop_idx_q, stop_idx_d, stop_bad;
  logic [7:0] out_data_q, out_data_d;
  logic       out_perr_q, out_perr_d, out_valid_q, out_valid_d;
  logic       ferr_pls_q, ferr_pls_d, ovr_pls_q, ovr_pls_d, brk_pls_q, brk_pls_d;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      sync1_q  <= 1'b1;
      rxs_q    <= 1'b1;
      rxs_d1_q <= 1'b1;
    end else begin
      sync1_q  <= rxd;
      rxs_q    <= sync1_q;
      rxs_d1_q <= rxs_q;
    end
  end

  assign fall = rxs_d1_q && !rxs_q;

  uart_os_tick #(.OVS(OVS), .DIV_W(DIV_W)) u_tick (
    .clk             (clk),
    .anrst           (anrst),
    .restart_i       (restart),
    .div_i           (baud_div),
    .tick_o          (tick),
    .phase_o         (phase),
    .sample_strobe_o (sample_strobe)
  );

  // The third sample is voted directly with the two stored ones; the result
  // and its strobe are registered so the FSM acts one clock later.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      smp_q  <= '0;
      bit_q  <= 1'b1;
      vote_q <= 1'b0;
    end else begin
      vote_q <= tick && (phase == PH_S2);
      if (sample_strobe) begin
        if (phase == PH_S0)      smp_q[0] <= rxs_q;
        else if (phase == PH_S1) smp_q[1] <= rxs_q;
        else bit_q <= (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
      end
    end
  end

  assign last_idx = {1'b0, bits_q} + 3'd4;
  assign nbits    = {2'b00, bits_q} + 4'd5;

  always_comb begin
    state_d     = state_q;
    bits_d      = bits_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    data_d      = data_q;
    idx_d       = idx_q;
    par_bit_d   = par_bit_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    stop_idx_d  = stop_idx_q;
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    out_valid_d = out_valid_q && !rx.rx_ready;
    ferr_pls_d  = 1'b0;
    ovr_pls_d   = 1'b0;
    brk_pls_d   = 1'b0;
    restart     = 1'b0;
    stop_bad    = 1'b0;
    case (state_q)
      ST_IDLE: if (fall) begin
        restart    = 1'b1;
        state_d    = ST_START;
        bits_d     = cfg_bits;
        par_d      = decode_parity(cfg_parity);
        stop2_d    = cfg_stop2;
        data_d     = '0;
        idx_d      = '0;
        par_bit_d  = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        stop_idx_d = 1'b0;
      end
      ST_START: if (vote_q) state_d = bit_q ? ST_IDLE : ST_DATA;
      ST_DATA: if (vote_q) begin
        data_d[idx_q] = bit_q;
        if (idx_q == last_idx) state_d = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
        else                   idx_d   = idx_q + 3'd1;
      end
      ST_PARITY: if (vote_q) begin
        par_bit_d = bit_q;
        perr_d    = bit_q ^ parity_of(data_q, nbits) ^ (par_q == PAR_ODD);
        state_d   = ST_STOP;
      end
      ST_STOP: if (vote_q) begin
        if (!stop_idx_q && !bit_q && data_q == '0 && !par_bit_q) begin
          brk_pls_d = 1'b1;
          state_d   = ST_BRK_WAIT;
        end else begin
          stop_bad = ferr_q | ~bit_q;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            ferr_d     = stop_bad;
          end else begin
            state_d    = ST_IDLE;
            ferr_pls_d = stop_bad;
            if (out_valid_q && !rx.rx_ready) begin
              ovr_pls_d = 1'b1;
            end else begin
              out_data_d  = data_q;
              out_perr_d  = perr_q;
              out_valid_d = 1'b1;
            end
          end
        end
      end
      ST_BRK_WAIT: if (rxs_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q     <= ST_IDLE;
      bits_q      <= '0;
      par_q       <= PAR_NONE;
      stop2_q     <= 1'b0;
      data_q      <= '0;
      idx_q       <= '0;
      par_bit_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      stop_idx_q  <= 1'b0;
      out_data_q  <= '0;
      out_perr_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ferr_pls_q  <= 1'b0;
      ovr_pls_q   <= 1'b0;
      brk_pls_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_q      <= bits_d;
      par_q       <= par_d;
      stop2_q     <= stop2_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      par_bit_q   <= par_bit_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      stop_idx_q  <= stop_idx_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      out_valid_q <= out_valid_d;
      ferr_pls_q  <= ferr_pls_d;
      ovr_pls_q   <= ovr_pls_d;
      brk_pls_q   <= brk_pls_d;
    end
  end

  assign rx.rx_data  = out_data_q;
  assign rx.rx_perr  = out_perr_q;
  assign rx.rx_valid = out_valid_q;
  assign rx_busy     = !(state_q == ST_IDLE || state_q == ST_BRK_WAIT);
  assign frame_err   = ferr_pls_q;
  assign overrun_err = ovr_pls_q;
  assign break_det   = brk_pls_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: serial frames are driven on rxd and the
// delivered words and error pulses are compared with hand-computed values.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        anrst;
  logic [15:0] baud_div = 16'd1;
  logic [1:0]  cfg_bits = 2'd3;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic        rxd = 1'b1;
  logic        rx_busy, frame_err, overrun_err, break_det;

  int total = 0, bad = 0, cyc = 0, div = 1;
  int acc_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, brk_cnt = 0;
  int rise_cyc = 0, fall_cyc = 0;
  logic [7:0] acc_data = '0;
  logic acc_perr = 1'b0, valid_prev = 1'b0;

  uart_rx_cfg_if rx_if ();

  uart_rx_cfg #(.OVS(16), .DIV_W(16)) dut (
    .clk         (clk),
    .anrst       (anrst),
    .baud_div    (baud_div),
    .cfg_bits    (cfg_bits),
    .cfg_parity  (cfg_parity),
    .cfg_stop2   (cfg_stop2),
    .rxd         (rxd),
    .rx          (rx_if),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .break_det   (break_det)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.rx_valid && rx_if.rx_ready) begin
      acc_cnt  <= acc_cnt + 1;
      acc_data <= rx_if.rx_data;
      acc_perr <= rx_if.rx_perr;
    end
    if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    if (overrun_err) ovr_cnt  <= ovr_cnt + 1;
    if (break_det)   brk_cnt  <= brk_cnt + 1;
    if (rx_if.rx_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= rx_if.rx_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bit time; an optional single-tick 1-spike lands on the first vote sample
  task automatic drive_bit(input logic v, input logic spk);
    rxd = v;
    if (spk) begin
      step(8 * div);
      rxd = 1'b1;
      step(div);
      rxd = v;
      step(7 * div);
    end else begin
      step(16 * div);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input int par, input logic st2,
                            input logic badpar, input logic stopv, input logic spk);
    logic p;
    fall_cyc = cyc;
    drive_bit(1'b0, 1'b0);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      drive_bit(d[i], spk && !d[i]);
      p ^= d[i];
    end
    if (par == 1)      drive_bit(p ^ badpar, 1'b0);
    else if (par == 2) drive_bit(~p ^ badpar, 1'b0);
    drive_bit(stopv, 1'b0);
    if (st2) drive_bit(1'b1, 1'b0);
  endtask

  task automatic set_cfg(input int d, input logic [1:0] b, input logic [1:0] p, input logic s2);
    div = d;
    baud_div = 16'(d);
    cfg_bits = b;
    cfg_parity = p;
    cfg_stop2 = s2;
  endtask

  task automatic test_reset;
    anrst = 1'b1;
    #1 anrst = 1'b0;
    step(3);
    total++;
    if (rx_if.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_if.rx_data); end
    total++;
    if ({rx_if.rx_valid, rx_if.rx_perr, rx_busy} !== 3'b000) begin
      bad++; $display("FAIL reset_status got=%b exp=000", {rx_if.rx_valid, rx_if.rx_perr, rx_busy});
    end
    total++;
    if ({frame_err, overrun_err, break_det} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses got=%b exp=000", {frame_err, overrun_err, break_det});
    end
    anrst = 1'b1;
    step(4);
  endtask

  task automatic test_basic;
    int a0, f0, o0, b0;
    set_cfg(1, 2'd3, 2'd0, 1'b0);
    a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt; b0 = brk_cnt;
    send_frame(8'hA5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32);
    total++;
    if (acc_cnt - a0 != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", acc_cnt - a0); end
    total++;
    if (acc_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", acc_data); end
    total++;
    if (acc_perr !== 1'b0) begin bad++; $display("FAIL basic_perr got=%b exp=0", acc_perr); end
    total++;
    if (ferr_cnt != f0 || ovr_cnt != o0 || brk_cnt != b0) begin
      bad++; $display("FAIL basic_errs got=%0d/%0d/%0d exp=0/0/0", ferr_cnt - f0, ovr_cnt - o0, brk_cnt - b0);
    end
    total++;
    if (rise_cyc - fall_cyc != 158) begin bad++; $display("FAIL basic_latency got=%0d exp=158", rise_cyc - fall_cyc); end
  endtask

  task automatic test_parity;
    int f0;
    f0 = ferr_cnt;
    set_cfg(3, 2'd2, 2'd1, 1'b1);
    send_frame(8'h41, 7, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(16 * div);
    total++;
    if ({acc_perr, acc_data} !== 9'h141) begin bad++; $display("FAIL par_bad got=%h exp=141", {acc_perr, acc_data}); end
    send_frame(8'h42, 7, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(16 * div);
    total++;
    if ({acc_perr, acc_data} !== 9'h042) begin bad++; $display("FAIL par_good got=%h exp=042", {acc_perr, acc_data}); end
    set_cfg(1, 2'd0, 2'd2, 1'b0);
    send_frame(8'h13, 5, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32);
    total++;
    if ({acc_perr, acc_data} !== 9'h013) begin bad++; $display("FAIL par_odd5 got=%h exp=013", {acc_perr, acc_data}); end
    send_frame(8'h13, 5, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    step(32);
    total++;
    if ({acc_perr, acc_data} !== 9'h113) begin bad++; $display("FAIL par_odd5_bad got=%h exp=113", {acc_perr, acc_data}); end
    total++;
    if (ferr_cnt != f0) begin bad++; $display("FAIL par_ferr got=%0d exp=0", ferr_cnt - f0); end
  endtask

  task automatic test_glitch;
    int a0;
    set_cfg(2, 2'd3, 2'd0, 1'b0);
    a0 = acc_cnt;
    rxd = 1'b0;
    step(5);
    total++;
    if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi got=%b exp=1", rx_busy); end
    step(4 * div - 5);
    rxd = 1'b1;
    step(32 * div);
    total++;
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_lo got=%b exp=0", rx_busy); end
    total++;
    if (acc_cnt != a0 || rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_word got=%0d exp=0", acc_cnt - a0); end
  endtask

  task automatic test_spike;
    int a0;
    set_cfg(2, 2'd3, 2'd0, 1'b0);
    a0 = acc_cnt;
    send_frame(8'h5A, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(16 * div);
    total++;
    if (acc_data !== 8'h5A) begin bad++; $display("FAIL spike_5a got=%h exp=5a", acc_data); end
    send_frame(8'h81, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(16 * div);
    total++;
    if (acc_data !== 8'h81) begin bad++; $display("FAIL spike_81 got=%h exp=81", acc_data); end
    total++;
    if (acc_cnt - a0 != 2) begin bad++; $display("FAIL spike_count got=%0d exp=2", acc_cnt - a0); end
  endtask

  task automatic test_back_to_back;
    int a0, o0;
    set_cfg(1, 2'd3, 2'd0, 1'b0);
    a0 = acc_cnt; o0 = ovr_cnt;
    rx_if.rx_ready = 1'b0;
    send_frame(8'h11, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h33, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(16);
    total++;
    if ({rx_if.rx_valid, rx_if.rx_data} !== 9'h111) begin
      bad++; $display("FAIL ovr_held got=%h exp=111", {rx_if.rx_valid, rx_if.rx_data});
    end
    total++;
    if (ovr_cnt - o0 != 2) begin bad++; $display("FAIL ovr_pulses got=%0d exp=2", ovr_cnt - o0); end
    rx_if.rx_ready = 1'b1;
    step(1);
    total++;
    if (acc_cnt - a0 != 1 || acc_data !== 8'h11) begin
      bad++; $display("FAIL ovr_read got=%0d/%h exp=1/11", acc_cnt - a0, acc_data);
    end
    total++;
    if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_drop got=%b exp=0", rx_if.rx_valid); end
    step(4);
  endtask

  task automatic test_break;
    int a0, f0, b0;
    set_cfg(1, 2'd3, 2'd0, 1'b0);
    a0 = acc_cnt; f0 = ferr_cnt; b0 = brk_cnt;
    rxd = 1'b0;
    step(20 * 16);
    rxd = 1'b1;
    step(32);
    total++;
    if (brk_cnt - b0 != 1) begin bad++; $display("FAIL brk_pulse got=%0d exp=1", brk_cnt - b0); end
    total++;
    if (ferr_cnt != f0 || acc_cnt != a0) begin
      bad++; $display("FAIL brk_side got=%0d/%0d exp=0/0", ferr_cnt - f0, acc_cnt - a0);
    end
    send_frame(8'h5A, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(16);
    total++;
    if (acc_cnt - a0 != 1 || acc_data !== 8'h5A) begin
      bad++; $display("FAIL brk_after got=%0d/%h exp=1/5a", acc_cnt - a0, acc_data);
    end
  endtask

  task automatic test_frame_err;
    int a0, f0, b0;
    set_cfg(1, 2'd3, 2'd0, 1'b0);
    a0 = acc_cnt; f0 = ferr_cnt; b0 = brk_cnt;
    send_frame(8'hC3, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rxd = 1'b1;
    step(32);
    total++;
    if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL ferr_pulse got=%0d exp=1", ferr_cnt - f0); end
    total++;
    if (acc_cnt - a0 != 1 || acc_data !== 8'hC3) begin
      bad++; $display("FAIL ferr_word got=%0d/%h exp=1/c3", acc_cnt - a0, acc_data);
    end
    total++;
    if (brk_cnt != b0) begin bad++; $display("FAIL ferr_brk got=%0d exp=0", brk_cnt - b0); end
  endtask

  task automatic test_mid_reset;
    int a0;
    set_cfg(1, 2'd3, 2'd0, 1'b0);
    a0 = acc_cnt;
    rxd = 1'b0;
    step(16);
    rxd = 1'b1;
    step(16 * 2 + 5);
    anrst = 1'b0;
    #1;
    total++;
    if ({rx_busy, rx_if.rx_valid, rx_if.rx_data} !== 10'h000) begin
      bad++; $display("FAIL mrst_outputs got=%h exp=000", {rx_busy, rx_if.rx_valid, rx_if.rx_data});
    end
    step(3);
    anrst = 1'b1;
    step(16 * 8);
    total++;
    if (acc_cnt != a0 || rx_busy !== 1'b0) begin
      bad++; $display("FAIL mrst_noword got=%0d/%b exp=0/0", acc_cnt - a0, rx_busy);
    end
    send_frame(8'h0F, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(16);
    total++;
    if (acc_cnt - a0 != 1 || acc_data !== 8'h0F) begin
      bad++; $display("FAIL mrst_next got=%0d/%h exp=1/0f", acc_cnt - a0, acc_data);
    end
  endtask

  initial begin
    rx_if.rx_ready = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_spike();
    test_back_to_back();
    test_break();
    test_frame_err();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Runtime-configurable UART receiver: the next generation of the team's fixed 8N1 receiver. It adds:
- a programmable baud divisor with 16x oversampling and a 3-sample majority vote;
- 5–8 data bits, no/even/odd parity, and 1 or 2 stop bits;
- break detection;
- a valid/ready output with overrun reporting.

It sits between the rxd pad and the command decoder.

## Interface
- OVS, 16: oversampling ratio, ticks per bit; even, ≥ 8.
- DIV_W, 16: width of the baud divisor.
- clk  in  1  system clock.
- anrst  in  1  reset; asynchronous, active-low.
- baud_div  in  DIV_W  clk cycles per oversample tick. 0 is treated as 1.
- cfg_bits  in  2  data bits minus 5 (0 = 5 bits … 3 = 8 bits).
- cfg_parity  in  2  parity mode: 0 none, 1 even, 2 odd, 3 none.
- cfg_stop2  in  1  1 = two stop bits checked.
- rxd  in  1  asynchronous serial input, idle high.
- rx_data  out  8  received word, LSB-aligned, unused MSBs 0.
- rx_perr  out  1  parity error flag belonging to rx_data.
- rx_valid  out  1  word available.
- rx_ready  in  1  consumer accepts the word.
- rx_busy  out  1  frame in progress.
- frame_err  out  1  one-cycle pulse: a stop bit sampled 0.
- overrun_err  out  1  one-cycle pulse: a completed word was dropped.
- break_det  out  1  one-cycle pulse: break condition detected.

## Operation
- **Synchroniser:** rxd passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised line rxs.
- **Config latch:** baud_div and all cfg_* inputs are captured when a start edge is detected. Changes mid-frame have no effect.
- **Tick generator:** tick_cnt loads baud_div-1 on start detect, counts down, and issues a tick at 0, then reloads. phase_cnt (log2 OVS bits) increments per tick and wraps at OVS-1.
- **Majority vote:** samples are taken at phases OVS/2-1, OVS/2 and OVS/2+1. The bit value is the majority of the three. The bit resolves at phase OVS/2+1.
- **States:** IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE: a falling edge on rxs goes to START. phase_cnt is cleared and the config is latched.
  - START: a voted 1 is a false start; return to IDLE with no output. A voted 0 goes to DATA.
  - DATA: shift the bit in LSB-first. After cfg_bits+5 bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: compare the received bit with the XOR of the data bits (even) or XNOR (odd).
  - STOP: check 1 or 2 stop bits. Completion happens at the vote of the last stop bit, not at bit end, so back-to-back frames are accepted.
- **Completion:** goes to IDLE, except for a break.
- **Break:** data all-zero, parity bit 0 (if enabled), and the first stop bit 0.
  - Pulse break_det only; no frame_err and no word delivered.
  - Go to BRK_WAIT, which returns to IDLE once rxs = 1.
- **Frame error:** any checked stop bit 0 and not a break. Pulse frame_err. The word is still delivered.
- **Output handshake:**
  - rx_valid stays high until the cycle where rx_ready = 1.
  - If a word completes while rx_valid = 1 and rx_ready = 0, the new word is dropped, the held word is kept, and overrun_err pulses.
  - If completion coincides with rx_valid & rx_ready, the new word is loaded and rx_valid stays 1.
- **rx_busy:** 1 in every state except IDLE and BRK_WAIT.
- **Reset:** asynchronous. Any state goes to IDLE immediately; any partial frame is discarded.
- **Reset values:** rx_data 0, rx_perr 0, rx_valid 0, rx_busy 0, all error pulses 0.

## Timing
- Start detect happens 3 clk after the rxd fall (2 synchroniser cycles plus 1 edge register).
- The bit-k vote resolves (k·OVS + OVS/2+2)·max(baud_div,1) clk after start detect, where k = 0 is the start bit.
- rx_valid, frame_err and overrun_err assert 1 clk after the last stop-bit vote. break_det asserts 1 clk after the first stop-bit vote.
- rx_valid falls 1 clk after the accept cycle. Back-to-back consumption is allowed: rx_ready may be held high permanently.
- All error outputs are registered single-cycle pulses.

## Structure
- Shared package uart_pkg:
  - parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD);
  - rx_state_t enum;
  - the OVS default;
  - the function parity_of(data, nbits).
- Sub-module uart_os_tick: baud divisor counter plus phase counter. It has a restart input and outputs tick, phase and sample_strobe. This module is reused by the planned configurable transmitter.
- Main FSM, shift register, voter and output register live in uart_rx_cfg.

## Test plan
- 8N1, baud_div 1, byte 0xA5 sent, rx_ready held 1:
  - rx_data = 0xA5 and rx_valid pulses exactly once;
  - rx_perr = 0 and there are no error pulses;
  - rx_valid asserts at 3 + (9·16+10)·1 + 1 clk after the rxd fall.
- 7E2, baud_div 3, 0x41 sent with a wrong parity bit: rx_data = 0x41 and rx_perr = 1. A following correct frame of 0x42 gives rx_perr = 0.
- Glitches and noise:
  - a 0-glitch of 4·baud_div clk on an idle line gives a false start: no rx_valid and rx_busy back to 0;
  - single-tick 1-spikes inside a data bit are voted out and the correct data is still received.
- Three back-to-back frames 0x11, 0x22, 0x33 with rx_ready = 0: rx_data = 0x11 is held and overrun_err pulses twice. After rx_ready, rx_data = 0x11 is read, then rx_valid = 0.
- rxd held low for 20 bit times:
  - break_det pulses once, with no frame_err and no rx_valid;
  - after rxd rises, frame 0x5A is received correctly.
- Mid-frame reset: anrst asserted during DATA of frame 0xFF, released while rxd is still in the frame.
  - Outputs go to reset values immediately.
  - No word is delivered.
  - The next full frame, 0x0F, is received correctly.
